// File: rtl/capture_pkg.sv
// Shared types and helpers for the trigger-based capture writer.
package capture_pkg;

  // Capture FSM state encoding.
  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    ARMED,
    POST,
    DONE
  } cap_state_t;

  // Number of words in a RAM with the given address width.
  function automatic int cap_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int CAP_ADDR_W = 10;
  localparam int CAP_DEPTH  = cap_depth(CAP_ADDR_W);

  // Effective post-trigger length: 0 behaves as 1, long requests are cut so
  // the window never overwrites its own pre-trigger history.
  function automatic logic [31:0] clamp_post_len(input logic [31:0] len,
                                                 input logic [31:0] max_len);
    if (len == 32'd0) begin
      return 32'd1;
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/capture_wr_ctrl.sv
// Trigger-based capture writer driving the A (write) port of the sample RAM.
// Keeps PRETRIG samples of circular history, writes post_len more after the
// trigger, then freezes and reports the window (start_addr, win_len).
// Optional feature: define CAPTURE_DECIM_EN to add the decim input, which
// accepts only every (decim+1)-th valid sample.
module capture_wr_ctrl
  import capture_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int PRETRIG = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              trig,
  input  logic [ADDR_W-1:0] post_len,
`ifdef CAPTURE_DECIM_EN
  input  logic [7:0]        decim,
`endif
  output logic              ram_ce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W:0]   win_len
);

  localparam int              DEPTH     = cap_depth(ADDR_W);
  localparam logic [31:0]     POST_MAX  = 32'(DEPTH - PRETRIG);
  localparam logic [ADDR_W-1:0] PRETRIG_A = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W:0]   PRETRIG_W = (ADDR_W + 1)'(PRETRIG);

  cap_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] fill_cnt_reg, fill_cnt_next;
  logic [ADDR_W-1:0] post_cnt_reg, post_cnt_next;
  logic [ADDR_W-1:0] post_eff_reg, post_eff_next;
  logic [ADDR_W-1:0] trig_addr_reg, trig_addr_next;
  logic              ram_wre_reg, ram_wre_next;
  logic [ADDR_W-1:0] ram_ad_reg, ram_ad_next;
  logic [DATA_W-1:0] ram_din_reg, ram_din_next;
  logic [ADDR_W-1:0] start_addr_reg, start_addr_next;
  logic [ADDR_W:0]   win_len_reg, win_len_next;
`ifdef CAPTURE_DECIM_EN
  logic [7:0]        decim_reg, decim_next;
  logic [7:0]        decim_cnt_reg, decim_cnt_next;
`endif

  logic              active;
  logic              take;
  logic              accept;
  logic [ADDR_W-1:0] eff_now;
  logic [ADDR_W-1:0] fill_inc;
  logic [ADDR_W-1:0] post_inc;

  // State register and all datapath registers; reset aborts any capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      fill_cnt_reg   <= '0;
      post_cnt_reg   <= '0;
      post_eff_reg   <= '0;
      trig_addr_reg  <= '0;
      ram_wre_reg    <= 1'b0;
      ram_ad_reg     <= '0;
      ram_din_reg    <= '0;
      start_addr_reg <= '0;
      win_len_reg    <= '0;
`ifdef CAPTURE_DECIM_EN
      decim_reg      <= '0;
      decim_cnt_reg  <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      fill_cnt_reg   <= fill_cnt_next;
      post_cnt_reg   <= post_cnt_next;
      post_eff_reg   <= post_eff_next;
      trig_addr_reg  <= trig_addr_next;
      ram_wre_reg    <= ram_wre_next;
      ram_ad_reg     <= ram_ad_next;
      ram_din_reg    <= ram_din_next;
      start_addr_reg <= start_addr_next;
      win_len_reg    <= win_len_next;
`ifdef CAPTURE_DECIM_EN
      decim_reg      <= decim_next;
      decim_cnt_reg  <= decim_cnt_next;
`endif
    end
  end

  // Next-state and write-path logic; arm always wins over sample/trigger.
  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    fill_cnt_next   = fill_cnt_reg;
    post_cnt_next   = post_cnt_reg;
    post_eff_next   = post_eff_reg;
    trig_addr_next  = trig_addr_reg;
    ram_wre_next    = 1'b0;
    ram_ad_next     = ram_ad_reg;
    ram_din_next    = ram_din_reg;
    start_addr_next = start_addr_reg;
    win_len_next    = win_len_reg;
    eff_now         = ADDR_W'(clamp_post_len(32'(post_len), POST_MAX));
    fill_inc        = fill_cnt_reg + ADDR_W'(1);
    post_inc        = post_cnt_reg + ADDR_W'(1);
    active          = (state_reg == PREFILL) || (state_reg == ARMED) ||
                      (state_reg == POST);
`ifdef CAPTURE_DECIM_EN
    decim_next      = decim_reg;
    decim_cnt_next  = decim_cnt_reg;
    take            = (decim_cnt_reg == 8'd0);
`else
    take            = 1'b1;
`endif
    accept          = active && s_valid && take && !arm;

    if (arm) begin
      state_next      = PREFILL;
      wr_ptr_next     = '0;
      fill_cnt_next   = '0;
      post_cnt_next   = '0;
      start_addr_next = '0;
      win_len_next    = '0;
`ifdef CAPTURE_DECIM_EN
      decim_next      = decim;
      decim_cnt_next  = 8'd0;
`endif
    end else begin
`ifdef CAPTURE_DECIM_EN
      // Decimation phase advances on every valid sample while capturing.
      if (active && s_valid) begin
        decim_cnt_next = (decim_cnt_reg == decim_reg) ? 8'd0 : decim_cnt_reg + 8'd1;
      end
`endif
      if (accept) begin
        ram_wre_next = 1'b1;
        ram_ad_next  = wr_ptr_reg;
        ram_din_next = s_data;
        wr_ptr_next  = wr_ptr_reg + ADDR_W'(1);
        case (state_reg)
          PREFILL: begin
            fill_cnt_next = fill_inc;
            if (fill_inc == PRETRIG_A) begin
              state_next = ARMED;
            end
          end
          ARMED: begin
            if (trig) begin
              trig_addr_next = wr_ptr_reg;
              post_eff_next  = eff_now;
              post_cnt_next  = ADDR_W'(1);
              if (eff_now == ADDR_W'(1)) begin
                state_next      = DONE;
                start_addr_next = wr_ptr_reg - PRETRIG_A;
                win_len_next    = PRETRIG_W + {1'b0, eff_now};
              end else begin
                state_next = POST;
              end
            end
          end
          POST: begin
            post_cnt_next = post_inc;
            if (post_inc == post_eff_reg) begin
              state_next      = DONE;
              start_addr_next = trig_addr_reg - PRETRIG_A;
              win_len_next    = PRETRIG_W + {1'b0, post_eff_reg};
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ram_wre    = ram_wre_reg;
  assign ram_ce     = ram_wre_reg;
  assign ram_ad     = ram_ad_reg;
  assign ram_din    = ram_din_reg;
  assign busy       = active;
  assign done       = (state_reg == DONE);
  assign start_addr = start_addr_reg;
  assign win_len    = win_len_reg;

endmodule
